fft_input_buffer: RTL

Upstream feeder for the 64-point fft core. It accepts a stream of complex 16-bit samples over a valid/ready handshake and packs them into the flat 1024-bit inputRe/inputIm buses that fft expects. When a frame is complete, or ends early on sampleLast, it issues a one-cycle start. It then holds the buses stable and stalls the stream until fft reports done.

---
 rtl/fft_input_buffer_if.sv | 21 ++
 rtl/fft_input_buffer.sv | 111 +++++++++++
 2 files changed

// File: rtl/fft_input_buffer_if.sv
// Sample stream into the fft input buffer: complex sample plus valid/ready/last.
// The master drives samples. The slave is the buffer, which returns sampleReady.
interface fft_input_buffer_if #(
    parameter int W = 16
);
    logic [W-1:0] sampleRe;
    logic [W-1:0] sampleIm;
    logic         sampleValid;
    logic         sampleLast;
    logic         sampleReady;

    modport master (
        output sampleRe, sampleIm, sampleValid, sampleLast,
        input  sampleReady
    );

    modport slave (
        input  sampleRe, sampleIm, sampleValid, sampleLast,
        output sampleReady
    );
endinterface

// File: rtl/fft_input_buffer.sv
// Packs a stream of complex samples into the flat fft input lanes and strobes start.
// The lanes are then frozen and the stream is stalled until fft signals done.
//
// state | meaning
// FILL  | accepting samples into lane[index]
// START | one-cycle start strobe, lanes frozen
// WAIT  | lanes frozen, waiting for a rising edge of fftDone
module fft_input_buffer #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fft_input_buffer_if.slave      s_in,
    input  logic                   fftDone,
    output logic [N*W-1:0]         inputRe,
    output logic [N*W-1:0]         inputIm,
    output logic                   start,
    output logic                   busy,
    output logic [$clog2(N):0]     sampleCount,
    output logic [15:0]            frameCount
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {FILL, START, WAIT} state_t;

    state_t         r_state;
    logic [IW-1:0]  r_index;
    logic [IW:0]    r_count;
    logic [N*W-1:0] r_re;
    logic [N*W-1:0] r_im;
    logic           r_start;
    logic           r_busy;
    logic [15:0]    r_frames;
    logic           r_done_prev;

    logic w_ready;
    logic w_accept;
    logic w_done_rise;

    assign w_ready     = (r_state == FILL) && rst;
    assign w_accept    = s_in.sampleValid && w_ready;
    assign w_done_rise = fftDone && !r_done_prev;

    assign s_in.sampleReady = w_ready;
    assign inputRe     = r_re;
    assign inputIm     = r_im;
    assign start       = r_start;
    assign busy        = r_busy;
    assign sampleCount = r_count;
    assign frameCount  = r_frames;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= FILL;
            r_index     <= '0;
            r_count     <= '0;
            r_re        <= '0;
            r_im        <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_frames    <= '0;
            r_done_prev <= 1'b0;
        end else begin
            // History tracks fftDone in every state so a level held from START is not an edge.
            r_done_prev <= fftDone;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < N; k++) begin
                            if (k == int'(r_index)) begin
                                r_re[k*W +: W] <= s_in.sampleRe;
                                r_im[k*W +: W] <= s_in.sampleIm;
                            end else if (s_in.sampleLast && (k > int'(r_index))) begin
                                r_re[k*W +: W] <= '0;
                                r_im[k*W +: W] <= '0;
                            end
                        end
                        if ((r_index == LAST_IDX) || s_in.sampleLast) begin
                            r_state  <= START;
                            r_index  <= '0;
                            r_count  <= '0;
                            r_start  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_frames <= r_frames + 16'd1;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                START: begin
                    r_start <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_done_rise) begin
                        r_state <= FILL;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
